// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequencer between the control unit and the multi-cycle
// multiplier/divider. Owns the architectural HI/LO registers, issues start
// pulses, waits for the unit's stop flag, commits results, and stalls the
// pipeline while an operation is in flight.
module muldiv_ctrl #(
  parameter int unsigned TIMEOUT = 40,
  parameter int unsigned CNT_W   = 6
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        OpValid,
  input  logic [2:0]  Op,
  input  logic [31:0] OpA,
  input  logic [31:0] OpB,
  output logic        MultStart,
  output logic [31:0] MultA,
  output logic [31:0] MultB,
  input  logic        MultStop,
  input  logic [31:0] MultHI,
  input  logic [31:0] MultLO,
  output logic        DivStart,
  output logic [31:0] DivA,
  output logic [31:0] DivB,
  input  logic        DivStop,
  input  logic [31:0] DivHI,
  input  logic [31:0] DivLO,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        Stall,
  output logic        Done,
  output logic        DivZero,
  output logic        Timeout
);

  localparam logic [2:0] OP_MULT = 3'b001;
  localparam logic [2:0] OP_DIV  = 3'b010;
  localparam logic [2:0] OP_MTHI = 3'b011;
  localparam logic [2:0] OP_MTLO = 3'b100;

  typedef enum logic [2:0] {
    IDLE, MUL_START, MUL_WAIT, DIV_START, DIV_WAIT, COMMIT
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             is_div;
  logic             req_mult, req_div, req_dz, wr_hi, wr_lo;
  logic             in_wait, unit_stop, stop_ok, to_hit;

  // Request decode; only meaningful while IDLE.
  always_comb begin
    req_mult = OpValid && (Op == OP_MULT);
    req_div  = OpValid && (Op == OP_DIV) && (OpB != '0);
    req_dz   = OpValid && (Op == OP_DIV) && (OpB == '0);
    wr_hi    = OpValid && (Op == OP_MTHI);
    wr_lo    = OpValid && (Op == OP_MTLO);
  end

  // Next-state logic, wait-state exit conditions and the combinational stall.
  always_comb begin
    state_nxt = state;
    in_wait   = (state == MUL_WAIT) || (state == DIV_WAIT);
    unit_stop = (state == DIV_WAIT) ? DivStop : MultStop;
    // First wait cycle (cnt == 0) masks a stop flag left over from the last op.
    stop_ok   = in_wait && unit_stop && (cnt != '0);
    // Stop has priority over timeout when both land on the same cycle.
    to_hit    = in_wait && !stop_ok && (cnt == CNT_W'(TIMEOUT - 1));
    case (state)
      IDLE: begin
        if (req_mult)     state_nxt = MUL_START;
        else if (req_div) state_nxt = DIV_START;
      end
      MUL_START: state_nxt = MUL_WAIT;
      DIV_START: state_nxt = DIV_WAIT;
      MUL_WAIT, DIV_WAIT: begin
        if (stop_ok)     state_nxt = COMMIT;
        else if (to_hit) state_nxt = IDLE;
      end
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    Stall = (state inside {MUL_START, MUL_WAIT, DIV_START, DIV_WAIT}) ||
            ((state == IDLE) && (req_mult || req_div));
  end

  // State register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Registered pulses and the wait counter, decoded from the upcoming state.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      MultStart <= 1'b0;
      DivStart  <= 1'b0;
      Done      <= 1'b0;
      DivZero   <= 1'b0;
      Timeout   <= 1'b0;
      cnt       <= '0;
    end else begin
      MultStart <= (state_nxt == MUL_START);
      DivStart  <= (state_nxt == DIV_START);
      Done      <= (state_nxt == COMMIT);
      DivZero   <= (state == IDLE) && req_dz;
      Timeout   <= to_hit;
      if ((state == MUL_START) || (state == DIV_START)) cnt <= '0;
      else if (in_wait)                                 cnt <= cnt + CNT_W'(1);
    end
  end

  // Operand latches, unit tracking flag and architectural HI/LO.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      MultA  <= '0;
      MultB  <= '0;
      DivA   <= '0;
      DivB   <= '0;
      HI     <= '0;
      LO     <= '0;
      is_div <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_mult) begin
            MultA  <= OpA;
            MultB  <= OpB;
            is_div <= 1'b0;
          end else if (req_div) begin
            DivA   <= OpA;
            DivB   <= OpB;
            is_div <= 1'b1;
          end
          if (wr_hi) HI <= OpA;
          if (wr_lo) LO <= OpA;
        end
        COMMIT: begin
          HI <= is_div ? DivHI : MultHI;
          LO <= is_div ? DivLO : MultLO;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: transaction-level model of the sequencer. Each operation's
// cycle timeline (request, start, wait, commit/timeout) sets per-cycle
// expectations; one compare process checks every DUT output each cycle.
module tb_muldiv_ctrl;

  localparam int unsigned TO = 40;
  localparam logic [2:0] NOP = 3'd0, MULT = 3'd1, DIV = 3'd2, MTHI = 3'd3,
                         MTLO = 3'd4, MFHI = 3'd5, MFLO = 3'd6, RSVD = 3'd7;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        OpValid = 1'b0;
  logic [2:0]  Op = 3'd0;
  logic [31:0] OpA = '0, OpB = '0;
  logic        MultStart, DivStart, Stall, Done, DivZero, Timeout;
  logic [31:0] MultA, MultB, DivA, DivB, HI, LO;
  logic        MultStop = 1'b0, DivStop = 1'b0;
  logic [31:0] MultHI = '0, MultLO = '0, DivHI = '0, DivLO = '0;

  muldiv_ctrl #(.TIMEOUT(TO), .CNT_W(6)) dut (
    .Clock(Clock), .Reset(Reset), .OpValid(OpValid), .Op(Op), .OpA(OpA), .OpB(OpB),
    .MultStart(MultStart), .MultA(MultA), .MultB(MultB), .MultStop(MultStop),
    .MultHI(MultHI), .MultLO(MultLO),
    .DivStart(DivStart), .DivA(DivA), .DivB(DivB), .DivStop(DivStop),
    .DivHI(DivHI), .DivLO(DivLO),
    .HI(HI), .LO(LO), .Stall(Stall), .Done(Done), .DivZero(DivZero), .Timeout(Timeout)
  );

  always #5 Clock = ~Clock;

  int unsigned vectors = 0, errors = 0;
  int unsigned n_ms = 0, n_ds = 0, n_done = 0, n_dz = 0, n_to = 0;
  logic chk_en = 1'b0;

  // Expected outputs for the current cycle.
  logic        e_ms = 0, e_ds = 0, e_done = 0, e_dz = 0, e_to = 0, e_stall = 0;
  logic [31:0] e_ma = '0, e_mb = '0, e_da = '0, e_db = '0, e_hi = '0, e_lo = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison, away from the active edge.
  always @(negedge Clock) begin
    if (chk_en) begin
      chk("MultStart", 32'(MultStart), 32'(e_ms));
      chk("DivStart",  32'(DivStart),  32'(e_ds));
      chk("Done",      32'(Done),      32'(e_done));
      chk("DivZero",   32'(DivZero),   32'(e_dz));
      chk("Timeout",   32'(Timeout),   32'(e_to));
      chk("Stall",     32'(Stall),     32'(e_stall));
      chk("MultA", MultA, e_ma);
      chk("MultB", MultB, e_mb);
      chk("DivA",  DivA,  e_da);
      chk("DivB",  DivB,  e_db);
      chk("HI",    HI,    e_hi);
      chk("LO",    LO,    e_lo);
    end
  end

  // Event counters used by the literal checks.
  always @(negedge Clock) begin
    if (MultStart === 1'b1) n_ms++;
    if (DivStart  === 1'b1) n_ds++;
    if (Done      === 1'b1) n_done++;
    if (DivZero   === 1'b1) n_dz++;
    if (Timeout   === 1'b1) n_to++;
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic clr();
    e_ms = 0; e_ds = 0; e_done = 0; e_dz = 0; e_to = 0;
  endtask

  task automatic idle_cycle();
    OpValid = 1'b0; Op = 3'($urandom_range(0, 7));
    clr(); e_stall = 0;
    tick();
  endtask

  // MULT/DIV. The unit raises stop in wait cycle k (k >= 1); k > TO-1 means
  // never. stale drives the unit's stop high during START and the first wait
  // cycle. abort_at >= 0 asserts reset asynchronously in that wait cycle.
  task automatic run_op(input bit dv, input logic [31:0] a, input logic [31:0] b,
                        input int k, input bit stale, input int abort_at);
    logic [63:0] p;
    logic [31:0] rh, rl;
    if (dv) begin
      rh = a % b; rl = a / b;
    end else begin
      p  = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      rh = p[63:32]; rl = p[31:0];
    end
    // Request cycle.
    OpValid = 1'b1; Op = dv ? DIV : MULT; OpA = a; OpB = b;
    clr(); e_stall = 1;
    tick();
    // Start cycle; the held pipeline keeps presenting the request.
    clr(); e_stall = 1;
    if (dv) begin
      e_ds = 1; e_da = a; e_db = b; DivStop = stale; DivHI = rh; DivLO = rl;
    end else begin
      e_ms = 1; e_ma = a; e_mb = b; MultStop = stale; MultHI = rh; MultLO = rl;
    end
    tick();
    // Wait cycles.
    for (int i = 0; i < int'(TO); i++) begin
      clr(); e_stall = 1;
      if (dv) DivStop  = (i == 0) ? stale : (i >= k);
      else    MultStop = (i == 0) ? stale : (i >= k);
      if (i == abort_at) begin
        chk_en = 1'b0;
        OpValid = 1'b0;
        #2 Reset = 1'b0;
        #1;
        chk("rst_MultStart", 32'(MultStart), 32'd0);
        chk("rst_Stall", 32'(Stall), 32'd0);
        chk("rst_Done", 32'(Done), 32'd0);
        chk("rst_HI", HI, 32'd0);
        chk("rst_LO", LO, 32'd0);
        chk("rst_MultA", MultA, 32'd0);
        chk("rst_MultB", MultB, 32'd0);
        e_hi = '0; e_lo = '0; e_ma = '0; e_mb = '0; e_da = '0; e_db = '0;
        e_stall = 0;
        tick();
        Reset = 1'b1;
        if (dv) DivStop = 1'b1; else MultStop = 1'b1;
        chk_en = 1'b1;
        return;
      end
      tick();
      if (k >= 1 && i == k) begin
        // Commit cycle: Stall released, result not yet visible.
        clr(); e_done = 1; e_stall = 0;
        tick();
        OpValid = 1'b0;
        clr(); e_stall = 0; e_hi = rh; e_lo = rl;
        tick();
        return;
      end
    end
    // Timed out: back in IDLE with a Timeout pulse, HI/LO untouched.
    if (dv) DivStop = 1'b0; else MultStop = 1'b0;
    OpValid = 1'b0;
    clr(); e_to = 1; e_stall = 0;
    tick();
  endtask

  task automatic div_zero(input logic [31:0] a);
    OpValid = 1'b1; Op = DIV; OpA = a; OpB = '0;
    clr(); e_stall = 0;
    tick();
    OpValid = 1'b0;
    clr(); e_dz = 1; e_stall = 0;
    tick();
  endtask

  // MTHI/MTLO followed by a register read (or other non-stalling op).
  task automatic move_to(input bit to_hi, input logic [31:0] d, input logic [2:0] nxt);
    OpValid = 1'b1; Op = to_hi ? MTHI : MTLO; OpA = d; OpB = $urandom;
    clr(); e_stall = 0;
    tick();
    if (to_hi) e_hi = d; else e_lo = d;
    Op = nxt; OpA = $urandom;
    clr(); e_stall = 0;
    tick();
    OpValid = 1'b0;
  endtask

  int unsigned ms0, ds0, dn0, dz0, to0;
  logic [2:0] misc_ops [4];

  initial begin
    misc_ops[0] = NOP; misc_ops[1] = MFHI; misc_ops[2] = MFLO; misc_ops[3] = RSVD;
    Reset = 1'b0;
    tick(); tick();
    chk_en = 1'b1;
    clr(); e_stall = 0;
    tick();
    chk("reset_HI", HI, 32'h0);
    chk("reset_LO", LO, 32'h0);
    Reset = 1'b1;
    tick();

    // MULT 7 * -3, 33 wait cycles.
    ms0 = n_ms; dn0 = n_done;
    run_op(1'b0, 32'd7, 32'hFFFF_FFFD, 32, 1'b0, -1);
    chk("mult_HI", HI, 32'hFFFF_FFFF);
    chk("mult_LO", LO, 32'hFFFF_FFEB);
    chk("mult_starts", n_ms - ms0, 32'd1);
    chk("mult_dones", n_done - dn0, 32'd1);

    // DIV 100 / 7, 34 wait cycles.
    ms0 = n_ms; ds0 = n_ds;
    run_op(1'b1, 32'd100, 32'd7, 33, 1'b0, -1);
    chk("div_HI", HI, 32'd2);
    chk("div_LO", LO, 32'd14);
    chk("div_starts", n_ds - ds0, 32'd1);
    chk("div_no_mult", n_ms - ms0, 32'd0);

    // DIV by zero with preloaded HI/LO.
    move_to(1'b1, 32'h11, NOP);
    move_to(1'b0, 32'h22, NOP);
    ds0 = n_ds; dz0 = n_dz;
    div_zero(32'd5);
    idle_cycle();
    chk("dz_pulses", n_dz - dz0, 32'd1);
    chk("dz_no_start", n_ds - ds0, 32'd0);
    chk("dz_HI", HI, 32'h11);
    chk("dz_LO", LO, 32'h22);

    // Hung multiplier with a stale stop in the first wait cycle.
    to0 = n_to; dn0 = n_done;
    run_op(1'b0, 32'd3, 32'd4, 1000, 1'b1, -1);
    chk("to_pulses", n_to - to0, 32'd1);
    chk("to_no_done", n_done - dn0, 32'd0);
    chk("to_HI", HI, 32'h11);
    move_to(1'b0, 32'hABCD, NOP);
    chk("mtlo_LO", LO, 32'hABCD);

    // MTHI then MFHI back to back.
    move_to(1'b1, 32'h1234_5678, MFHI);
    chk("mthi_HI", HI, 32'h1234_5678);

    // Stop arriving on the last wait cycle beats the timeout.
    to0 = n_to;
    run_op(1'b0, 32'h8000_0000, 32'd2, int'(TO) - 1, 1'b1, -1);
    chk("edge_no_to", n_to - to0, 32'd0);
    chk("edge_HI", HI, 32'hFFFF_FFFF);
    chk("edge_LO", LO, 32'h0);

    // Randomized mix.
    for (int n = 0; n < 40; n++) begin
      int unsigned r;
      logic [31:0] b;
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: run_op(1'b0, $urandom, $urandom, int'($urandom_range(1, 45)),
                        1'($urandom_range(0, 1)), -1);
        3, 4: begin
          b = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 300)) : $urandom;
          if (b == 0) b = 1;
          run_op(1'b1, $urandom, b, int'($urandom_range(1, 45)),
                 1'($urandom_range(0, 1)), -1);
        end
        5: div_zero($urandom);
        6: move_to(1'b1, $urandom, misc_ops[$urandom_range(0, 3)]);
        7: move_to(1'b0, $urandom, misc_ops[$urandom_range(0, 3)]);
        8: begin
          OpValid = 1'b1; Op = misc_ops[$urandom_range(0, 3)];
          OpA = $urandom; OpB = $urandom;
          clr(); e_stall = 0;
          tick();
          OpValid = 1'b0;
        end
        default: idle_cycle();
      endcase
    end

    // Asynchronous reset in the middle of a multiply wait.
    dn0 = n_done;
    run_op(1'b0, 32'd9, 32'd9, 30, 1'b0, 5);
    for (int i = 0; i < 4; i++) idle_cycle();
    chk("abort_no_done", n_done - dn0, 32'd0);
    chk("abort_HI", HI, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
